// File: rtl/sp_pkg.sv
// Shared constants, host state encoding and beat-payload helpers for the SP host.
package sp_pkg;

    localparam int DATA_W     = 16;
    localparam int N_WORDS    = 6;
    localparam int N_MODES    = 3;
    localparam int MODE_W     = 3;
    localparam int SP_MOD     = 509;
    localparam int SEND_BEATS = N_MODES + N_WORDS;
    localparam int IDX_W      = 3;
    localparam int BEAT_W     = 4;
    localparam int MODES_W    = N_MODES * MODE_W;
    localparam int WORDS_W    = N_WORDS * DATA_W;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SEND = 3'd1,
        ST_WAIT = 3'd2,
        ST_RECV = 3'd3,
        ST_RESP = 3'd4
    } host_state_e;

    // Mode code carried on a given serial beat; zero on data beats.
    function automatic logic [MODE_W-1:0] beat_mode(input logic [BEAT_W-1:0] beat,
                                                    input logic [MODES_W-1:0] modes);
        logic [MODE_W-1:0] m;
        if (beat < BEAT_W'(N_MODES)) begin
            m = modes[int'(beat)*MODE_W +: MODE_W];
        end else begin
            m = {MODE_W{1'b0}};
        end
        return m;
    endfunction

    // Data word carried on a given serial beat; zero on mode beats.
    function automatic logic [DATA_W-1:0] beat_data(input logic [BEAT_W-1:0] beat,
                                                    input logic [WORDS_W-1:0] words);
        logic [DATA_W-1:0] d;
        if (beat >= BEAT_W'(N_MODES) && beat < BEAT_W'(SEND_BEATS)) begin
            d = words[(int'(beat) - N_MODES)*DATA_W +: DATA_W];
        end else begin
            d = {DATA_W{1'b0}};
        end
        return d;
    endfunction

endpackage

// File: rtl/sp_host_if.sv
// Job request, SP serial link and result handshake bundled for the SP host.
interface sp_host_if;
    import sp_pkg::*;

    logic               req_valid;
    logic               req_ready;
    logic [MODES_W-1:0] req_mode;
    logic [WORDS_W-1:0] req_data;
    logic               sp_in_valid;
    logic [DATA_W-1:0]  sp_in_data;
    logic [MODE_W-1:0]  sp_in_mode;
    logic               sp_out_valid;
    logic [DATA_W-1:0]  sp_out_data;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [WORDS_W-1:0] rsp_data;
    logic               rsp_err;

    // Environment side: offers jobs, plays the SP core, consumes results.
    modport master (
        output req_valid, req_mode, req_data, sp_out_valid, sp_out_data, rsp_ready,
        input  req_ready, sp_in_valid, sp_in_data, sp_in_mode, rsp_valid, rsp_data, rsp_err
    );

    // Host side.
    modport slave (
        input  req_valid, req_mode, req_data, sp_out_valid, sp_out_data, rsp_ready,
        output req_ready, sp_in_valid, sp_in_data, sp_in_mode, rsp_valid, rsp_data, rsp_err
    );

endinterface

// File: rtl/sp_burst_rx.sv
// Collects the SP output burst: timeout wait, word capture, length error.
module sp_burst_rx
    import sp_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               i_clear,
    input  logic               i_wait,
    input  logic               i_recv,
    input  logic               i_valid,
    input  logic [DATA_W-1:0]  i_data,
    output logic               o_done,
    output logic               o_err,
    output logic [WORDS_W-1:0] o_words
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0]   r_cnt;
    logic [IDX_W-1:0]   r_idx;
    logic               r_ovf;
    logic [WORDS_W-1:0] r_words;

    // Capture state: cleared while the job is being sent, so each result starts empty.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt   <= {CNT_W{1'b0}};
            r_idx   <= {IDX_W{1'b0}};
            r_ovf   <= 1'b0;
            r_words <= {WORDS_W{1'b0}};
        end else if (i_clear) begin
            r_cnt   <= {CNT_W{1'b0}};
            r_idx   <= {IDX_W{1'b0}};
            r_ovf   <= 1'b0;
            r_words <= {WORDS_W{1'b0}};
        end else if (i_wait) begin
            if (i_valid) begin
                r_words[DATA_W-1:0] <= i_data;
                r_idx               <= 3'd1;
            end else if (r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end else if (i_recv && i_valid) begin
            if (r_idx < IDX_W'(N_WORDS)) begin
                r_words[int'(r_idx)*DATA_W +: DATA_W] <= i_data;
                r_idx                                 <= r_idx + 3'd1;
            end else begin
                r_ovf <= 1'b1;
            end
        end
    end

    // Completion: a silent wait that uses up its budget, or the first idle cycle of a burst.
    always_comb begin
        o_done = 1'b0;
        o_err  = 1'b0;
        if (i_wait) begin
            o_done = !i_valid && (r_cnt >= CNT_LAST);
            o_err  = 1'b1;
        end else if (i_recv) begin
            o_done = !i_valid;
            o_err  = r_ovf || (r_idx < IDX_W'(N_WORDS));
        end else begin
            o_done = 1'b0;
            o_err  = 1'b0;
        end
    end

    assign o_words = r_words;

endmodule

// File: rtl/sp_host.sv
// SP host: accepts a job, serializes it to the SP core, returns the collected burst.
module sp_host
    import sp_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic     clk,
    input  logic     rstn,
    sp_host_if.slave bus
);

    host_state_e        r_state, w_state_nx;
    logic [BEAT_W-1:0]  r_beat, w_beat_nx;
    logic [MODES_W-1:0] r_mode, w_mode_nx;
    logic [WORDS_W-1:0] r_data, w_data_nx;
    logic               r_req_ready, w_req_ready_nx;
    logic               r_in_valid, w_in_valid_nx;
    logic [DATA_W-1:0]  r_in_data, w_in_data_nx;
    logic [MODE_W-1:0]  r_in_mode, w_in_mode_nx;
    logic               r_rsp_valid, w_rsp_valid_nx;
    logic [WORDS_W-1:0] r_rsp_data, w_rsp_data_nx;
    logic               r_rsp_err, w_rsp_err_nx;

    logic               w_rx_clear, w_rx_wait, w_rx_recv;
    logic               w_rx_done, w_rx_err;
    logic [WORDS_W-1:0] w_rx_words;

    assign w_rx_clear = (r_state == ST_SEND);
    assign w_rx_wait  = (r_state == ST_WAIT);
    assign w_rx_recv  = (r_state == ST_RECV);

    sp_burst_rx #(.TIMEOUT(TIMEOUT)) u_rx (
        .clk     (clk),
        .rstn    (rstn),
        .i_clear (w_rx_clear),
        .i_wait  (w_rx_wait),
        .i_recv  (w_rx_recv),
        .i_valid (bus.sp_out_valid),
        .i_data  (bus.sp_out_data),
        .o_done  (w_rx_done),
        .o_err   (w_rx_err),
        .o_words (w_rx_words)
    );

    // State and every output register; reset drops the job and all outputs at once.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= ST_IDLE;
            r_beat      <= {BEAT_W{1'b0}};
            r_mode      <= {MODES_W{1'b0}};
            r_data      <= {WORDS_W{1'b0}};
            r_req_ready <= 1'b0;
            r_in_valid  <= 1'b0;
            r_in_data   <= {DATA_W{1'b0}};
            r_in_mode   <= {MODE_W{1'b0}};
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= {WORDS_W{1'b0}};
            r_rsp_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_beat      <= w_beat_nx;
            r_mode      <= w_mode_nx;
            r_data      <= w_data_nx;
            r_req_ready <= w_req_ready_nx;
            r_in_valid  <= w_in_valid_nx;
            r_in_data   <= w_in_data_nx;
            r_in_mode   <= w_in_mode_nx;
            r_rsp_valid <= w_rsp_valid_nx;
            r_rsp_data  <= w_rsp_data_nx;
            r_rsp_err   <= w_rsp_err_nx;
        end
    end

    // Next state and next register values; serial outputs are zero unless a beat is due.
    always_comb begin
        w_state_nx     = r_state;
        w_beat_nx      = r_beat;
        w_mode_nx      = r_mode;
        w_data_nx      = r_data;
        w_req_ready_nx = 1'b0;
        w_in_valid_nx  = 1'b0;
        w_in_data_nx   = {DATA_W{1'b0}};
        w_in_mode_nx   = {MODE_W{1'b0}};
        w_rsp_valid_nx = r_rsp_valid;
        w_rsp_data_nx  = r_rsp_data;
        w_rsp_err_nx   = r_rsp_err;
        case (r_state)
            ST_IDLE: begin
                if (bus.req_valid && r_req_ready) begin
                    w_state_nx    = ST_SEND;
                    w_mode_nx     = bus.req_mode;
                    w_data_nx     = bus.req_data;
                    w_beat_nx     = {BEAT_W{1'b0}};
                    w_in_valid_nx = 1'b1;
                    w_in_mode_nx  = beat_mode({BEAT_W{1'b0}}, bus.req_mode);
                end else begin
                    w_req_ready_nx = 1'b1;
                end
            end
            ST_SEND: begin
                if (r_beat == BEAT_W'(SEND_BEATS - 1)) begin
                    w_state_nx = ST_WAIT;
                end else begin
                    w_beat_nx     = r_beat + 4'd1;
                    w_in_valid_nx = 1'b1;
                    w_in_mode_nx  = beat_mode(w_beat_nx, r_mode);
                    w_in_data_nx  = beat_data(w_beat_nx, r_data);
                end
            end
            ST_WAIT, ST_RECV: begin
                if (r_state == ST_WAIT && bus.sp_out_valid) begin
                    w_state_nx = ST_RECV;
                end else if (w_rx_done) begin
                    w_state_nx     = ST_RESP;
                    w_rsp_valid_nx = 1'b1;
                    w_rsp_data_nx  = w_rx_words;
                    w_rsp_err_nx   = w_rx_err;
                end else begin
                    w_state_nx = r_state;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    w_state_nx     = ST_IDLE;
                    w_rsp_valid_nx = 1'b0;
                    w_rsp_data_nx  = {WORDS_W{1'b0}};
                    w_rsp_err_nx   = 1'b0;
                    w_req_ready_nx = 1'b1;
                end else begin
                    w_state_nx = ST_RESP;
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    assign bus.req_ready   = r_req_ready;
    assign bus.sp_in_valid = r_in_valid;
    assign bus.sp_in_data  = r_in_data;
    assign bus.sp_in_mode  = r_in_mode;
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_data    = r_rsp_data;
    assign bus.rsp_err     = r_rsp_err;

endmodule

// File: doc/sp_host.md
Name: sp_host

Overview:
- Host-side driver for the SP processing core. It sits on the other end of the SP core's serial interface.
- Accepts one parallel job (3 mode codes + 6 data words) through a valid/ready handshake and serializes it onto the SP input bus.
- Collects the SP output burst into a parallel result and returns it, with an error flag, through a second valid/ready handshake.
- Exactly one job is outstanding at a time.

Parameters:
- DATA_W, 16, width of each data word
- N_WORDS, 6, data words per job and per result
- N_MODES, 3, mode codes per job (3 bits each)
- TIMEOUT, 255, maximum cycles to wait for the first sp_out_valid before aborting

Ports:
- clk  in  1  single clock, rising edge
- rstn  in  1  asynchronous active-low reset
- req_valid  in  1  job offered
- req_ready  out  1  block idle, can accept a job
- req_mode  in  9  mode[i] = req_mode[3*i +: 3]
- req_data  in  96  A[i] = req_data[16*i +: 16]
- sp_in_valid  out  1  to SP in_valid
- sp_in_data  out  16  to SP in_data
- sp_in_mode  out  3  to SP in_mode
- sp_out_valid  in  1  from SP out_valid
- sp_out_data  in  16  from SP out_data
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_data  out  96  word i = rsp_data[16*i +: 16], i = order of receipt
- rsp_err  out  1  burst length not N_WORDS, or timeout

Behaviour:
- Reset and registered outputs:
  - Clock is clk; reset is rstn, asynchronous active-low.
  - While rstn = 0, all outputs are 0 and the state is IDLE.
  - All outputs are registered. req_ready rises on the first clock edge after reset release.
- States: IDLE -> SEND -> WAIT -> RECV -> RESP -> IDLE.
- IDLE:
  - req_ready = 1.
  - On req_valid && req_ready, latch req_mode and req_data, drop req_ready, go to SEND.
- SEND:
  - sp_in_valid is high for exactly N_MODES + N_WORDS = 9 consecutive cycles, starting the cycle after acceptance.
  - Beats 0-2: sp_in_mode = mode[beat], sp_in_data = 0.
  - Beats 3-8: sp_in_data = A[beat-3], sp_in_mode = 0.
  - After beat 8: sp_in_valid, sp_in_data and sp_in_mode return to 0; go to WAIT.
- WAIT:
  - The timeout counter is cleared on entry and increments each cycle.
  - If sp_out_valid = 1: capture that word as word 0, word count = 1, go to RECV.
  - If the counter reaches TIMEOUT with no sp_out_valid: go to RESP with rsp_err = 1 and rsp_data = 0.
- RECV:
  - Each cycle sp_out_valid = 1, store sp_out_data at the current word index while index < N_WORDS.
  - Words beyond N_WORDS are discarded and set the err flag.
  - The first cycle with sp_out_valid = 0 ends the burst.
  - If count < N_WORDS, set err; unreceived words are 0.
  - Go to RESP.
- RESP:
  - rsp_valid = 1. rsp_data and rsp_err are held stable while rsp_valid && !rsp_ready.
  - On the handshake, clear rsp_valid, go to IDLE. req_ready = 1 the next cycle.
  - Minimum job-to-job turnaround: accept, 9 SEND cycles, WAIT, burst, 1 RESP cycle, 1 IDLE cycle.
- Boundary conditions:
  - sp_out_valid in IDLE, SEND or RESP is ignored and does not affect the next result.
  - A burst starting on the same edge the timeout counter hits TIMEOUT counts as received; the burst wins.
  - req_valid outside IDLE is ignored. The request source must hold it until req_ready.
  - rsp_ready while rsp_valid = 0 is ignored.
  - Reset mid-job (any state): immediate return to IDLE, outputs 0, captured data cleared. No partial result is ever presented.
  - The counter is wide enough for TIMEOUT (8 bits at the default) and saturates, never wraps.
- Width rules: the word index is 3 bits and saturates at N_WORDS. No arithmetic is performed on data; words pass through unmodified.

Decomposition:
- Package sp_pkg:
  - DATA_W, N_WORDS, N_MODES, MODE_W = 3, SP_MOD = 509 (shared with the core for future result checking).
  - Host state enum.
  - Beat-count constant SEND_BEATS = N_MODES + N_WORDS.
- One sub-module: sp_burst_rx.
  - Contains the WAIT/RECV capture, word index, timeout counter and err generation.
  - Exposes done, err and a 96-bit words bus to the sp_host FSM.
- The serializer stays in sp_host.

Test Plan:
1. Modes {1,1,1}, A = {1,2,3,4,5,6}; SP model answers with a 6-word burst {10..15} -> sp_in beats exactly 1,1,1,1,2,3,4,5,6; rsp_data = {10..15}; rsp_err = 0; req_ready back 1 cycle after rsp handshake.
2. TIMEOUT = 20; SP model silent -> rsp_valid exactly 21 cycles after the last SEND beat; rsp_err = 1; rsp_data = 0.
3. Short burst of 4 words {7,8,9,10} -> words 0-3 = 7..10, words 4-5 = 0, rsp_err = 1.
4. Long burst of 8 words {20..27} -> rsp_data = {20..25}, rsp_err = 1.
5. rsp_ready held low 5 cycles -> rsp_valid, rsp_data and rsp_err constant; req_ready = 0; a req_valid pulse in that window is not accepted.
6. rstn low during SEND beat 4 -> sp_in_valid = 0 without waiting for a clock edge; after release, job {0,0,0}/{100..105} completes with correct beats and rsp_err = 0.
